// File: rtl/control_flujo_fsm.sv
// control_flujo_fsm: flow-control FSM for the FIFO switch datapath.
// Latches and validates low/high occupancy thresholds, derives per-FIFO
// almost-empty/almost-full flags, drives global backpressure (pausa) and
// keeps a sticky ERROR state fed by per-FIFO overflow/underflow pulses.
// Every output is registered and reflects the state entered at the edge.
module control_flujo_fsm #(
    parameter int N_FIFOS  = 8,
    parameter int W_OCUP   = 4,
    parameter int DEPTH    = 8,
    parameter int BAJO_DEF = 1,
    parameter int ALTO_DEF = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic [W_OCUP-1:0]           bajo,
    input  logic [W_OCUP-1:0]           alto,
    input  logic [N_FIFOS*W_OCUP-1:0]   ocupacion,
    input  logic [N_FIFOS-1:0]          empty_fifos,
    input  logic [N_FIFOS-1:0]          error_fifos,
    output logic [2:0]                  estado,
    output logic [W_OCUP-1:0]           bajo_out,
    output logic [W_OCUP-1:0]           alto_out,
    output logic [N_FIFOS-1:0]          almost_empty,
    output logic [N_FIFOS-1:0]          almost_full,
    output logic                        pausa,
    output logic                        idle_out,
    output logic                        active_out,
    output logic                        error_out,
    output logic [N_FIFOS-1:0]          error_id
);

    typedef enum logic [2:0] {
        S_RESET  = 3'b000,
        S_INIT   = 3'b001,
        S_IDLE   = 3'b010,
        S_ACTIVE = 3'b011,
        S_ERROR  = 3'b100
    } estado_t;

    localparam logic [W_OCUP-1:0] BAJO_RST = W_OCUP'(BAJO_DEF);
    localparam logic [W_OCUP-1:0] ALTO_RST = W_OCUP'(ALTO_DEF);
    localparam logic [W_OCUP-1:0] DEPTH_C  = W_OCUP'(DEPTH);

    estado_t              estado_q, estado_d;
    logic [W_OCUP-1:0]    bajo_q, bajo_d;
    logic [W_OCUP-1:0]    alto_q, alto_d;
    logic [N_FIFOS-1:0]   ae_q, ae_d;
    logic [N_FIFOS-1:0]   af_q, af_d;
    logic [N_FIFOS-1:0]   eid_q, eid_d;
    logic                 pausa_q, pausa_d;
    logic                 idle_q, idle_d;
    logic                 active_q, active_d;
    logic                 error_q, error_d;

    logic [N_FIFOS-1:0]   ae_cmp, af_cmp;
    logic                 par_ok;

    // Candidate thresholds are usable only if ordered and within the FIFO depth.
    assign par_ok = (bajo < alto) && (alto <= DEPTH_C);

    // Per-FIFO occupancy compared against the thresholds latched before this edge.
    always_comb begin
        ae_cmp = '0;
        af_cmp = '0;
        for (int i = 0; i < N_FIFOS; i++) begin
            ae_cmp[i] = (ocupacion[i*W_OCUP +: W_OCUP] <= bajo_q);
            af_cmp[i] = (ocupacion[i*W_OCUP +: W_OCUP] >= alto_q);
        end
    end

    // Next state with error > init > empty priority, plus next registered outputs.
    always_comb begin
        estado_d = estado_q;
        bajo_d   = bajo_q;
        alto_d   = alto_q;
        ae_d     = ae_q;
        af_d     = af_q;
        eid_d    = eid_q;
        pausa_d  = 1'b0;
        idle_d   = 1'b0;
        active_d = 1'b0;
        error_d  = 1'b0;

        case (estado_q)
            S_RESET: estado_d = S_INIT;
            S_INIT, S_IDLE, S_ACTIVE: begin
                if (|error_fifos) begin
                    estado_d = S_ERROR;
                end else if (init) begin
                    estado_d = S_INIT;
                end else if (estado_q == S_INIT) begin
                    estado_d = S_IDLE;
                end else if (&empty_fifos) begin
                    estado_d = S_IDLE;
                end else begin
                    estado_d = S_ACTIVE;
                end
            end
            S_ERROR: estado_d = S_ERROR;
            default: estado_d = S_RESET;
        endcase

        // Thresholds are only programmable while sitting in INIT.
        if (estado_q == S_INIT && par_ok) begin
            bajo_d = bajo;
            alto_d = alto;
        end

        // Flags freeze once ERROR is entered; the fault record accumulates there.
        if (estado_d == S_ERROR) begin
            eid_d = eid_q | error_fifos;
        end else begin
            ae_d = ae_cmp;
            af_d = af_cmp;
        end

        case (estado_d)
            S_INIT, S_ERROR:  pausa_d = 1'b1;
            S_IDLE, S_ACTIVE: pausa_d = |af_d;
            default:          pausa_d = 1'b0;
        endcase

        idle_d   = (estado_d == S_IDLE);
        active_d = (estado_d == S_ACTIVE);
        error_d  = (estado_d == S_ERROR);
    end

    // State and output registers; reset restores defaults and clears the fault record.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= S_RESET;
            bajo_q   <= BAJO_RST;
            alto_q   <= ALTO_RST;
            ae_q     <= '0;
            af_q     <= '0;
            eid_q    <= '0;
            pausa_q  <= 1'b0;
            idle_q   <= 1'b0;
            active_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            bajo_q   <= bajo_d;
            alto_q   <= alto_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            eid_q    <= eid_d;
            pausa_q  <= pausa_d;
            idle_q   <= idle_d;
            active_q <= active_d;
            error_q  <= error_d;
        end
    end

    assign estado       = estado_q;
    assign bajo_out     = bajo_q;
    assign alto_out     = alto_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign pausa        = pausa_q;
    assign idle_out     = idle_q;
    assign active_out   = active_q;
    assign error_out    = error_q;
    assign error_id     = eid_q;

endmodule

// File: tb/tb_control_flujo_fsm.sv
// Bench for control_flujo_fsm: two instances (8x4-bit depth 8, and 4x5-bit
// depth 16) driven by directed scenarios then random traffic, each checked
// every cycle against a behavioural model plus literal expectations.
module tb_control_flujo_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ini;
    logic [3:0]  bajoA, altoA;
    logic [31:0] occA;
    logic [7:0]  empA, errA;
    logic [4:0]  bajoB, altoB;
    logic [19:0] occB;
    logic [3:0]  empB, errB;

    logic [2:0]  estA, estB;
    logic [3:0]  boA, aoA;
    logic [4:0]  boB, aoB;
    logic [7:0]  aeA, afA, eidA;
    logic [3:0]  aeB, afB, eidB;
    logic        pA, idA, acA, erA, pB, idB, acB, erB;

    control_flujo_fsm #(.N_FIFOS(8), .W_OCUP(4), .DEPTH(8), .BAJO_DEF(1), .ALTO_DEF(6)) dut_a (
        .clk(clk), .reset(rst), .init(ini), .bajo(bajoA), .alto(altoA),
        .ocupacion(occA), .empty_fifos(empA), .error_fifos(errA),
        .estado(estA), .bajo_out(boA), .alto_out(aoA), .almost_empty(aeA),
        .almost_full(afA), .pausa(pA), .idle_out(idA), .active_out(acA),
        .error_out(erA), .error_id(eidA));

    control_flujo_fsm #(.N_FIFOS(4), .W_OCUP(5), .DEPTH(16), .BAJO_DEF(1), .ALTO_DEF(6)) dut_b (
        .clk(clk), .reset(rst), .init(ini), .bajo(bajoB), .alto(altoB),
        .ocupacion(occB), .empty_fifos(empB), .error_fifos(errB),
        .estado(estB), .bajo_out(boB), .alto_out(aoB), .almost_empty(aeB),
        .almost_full(afB), .pausa(pB), .idle_out(idB), .active_out(acB),
        .error_out(erB), .error_id(eidB));

    // Model state: st uses the documented encodings 0 RESET .. 4 ERROR.
    typedef struct {
        int       st;
        int       bo;
        int       ao;
        bit [7:0] ae;
        bit [7:0] af;
        bit [7:0] eid;
        bit       p;
    } mdl_t;

    mdl_t mA, mB;
    int n_chk = 0;
    int n_fail = 0;

    function automatic mdl_t step(mdl_t m, int n, int w, int depth, bit r_, bit in_,
                                  int b, int a, logic [39:0] occ,
                                  logic [7:0] emp, logic [7:0] err);
        mdl_t r;
        bit [7:0] msk;
        int nxt;
        int o;
        r = m;
        msk = 8'((1 << n) - 1);
        if (r_) begin
            r.st = 0; r.bo = 1; r.ao = 6; r.ae = 0; r.af = 0; r.eid = 0; r.p = 0;
            return r;
        end
        if (m.st == 0)                nxt = 1;
        else if (m.st == 4)           nxt = 4;
        else if ((err & msk) != 0)    nxt = 4;
        else if (in_)                 nxt = 1;
        else if (m.st == 1)           nxt = 2;
        else if ((emp & msk) == msk)  nxt = 2;
        else                          nxt = 3;
        if (m.st == 1 && b < a && a <= depth) begin
            r.bo = b;
            r.ao = a;
        end
        if (nxt == 4) begin
            r.eid = m.eid | (err & msk);
        end else begin
            for (int i = 0; i < n; i++) begin
                o = 0;
                for (int j = 0; j < w; j++) o = o | (int'(occ[i*w + j]) << j);
                r.ae[i] = (o <= m.bo);
                r.af[i] = (o >= m.ao);
            end
        end
        if (nxt == 1 || nxt == 4) r.p = 1'b1;
        else                      r.p = |r.af;
        r.st = nxt;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, $time, act, act, exp, exp);
        end
    endtask

    task automatic cmp(input string t, input mdl_t m, input logic [2:0] est,
                       input int bo, input int ao, input logic [7:0] ae,
                       input logic [7:0] af, input logic [7:0] eid,
                       input logic p, input logic id, input logic ac, input logic er);
        chk({t, ".estado"}, int'(est), m.st);
        chk({t, ".bajo_out"}, bo, m.bo);
        chk({t, ".alto_out"}, ao, m.ao);
        chk({t, ".almost_empty"}, int'(ae), int'(m.ae));
        chk({t, ".almost_full"}, int'(af), int'(m.af));
        chk({t, ".error_id"}, int'(eid), int'(m.eid));
        chk({t, ".pausa"}, int'(p), int'(m.p));
        chk({t, ".idle_out"}, int'(id), int'(m.st == 2));
        chk({t, ".active_out"}, int'(ac), int'(m.st == 3));
        chk({t, ".error_out"}, int'(er), int'(m.st == 4));
    endtask

    // One clock: advance both models on the sampled inputs, then compare.
    task automatic tick();
        @(posedge clk);
        mA = step(mA, 8, 4, 8, rst, ini, int'(bajoA), int'(altoA), 40'(occA), empA, errA);
        mB = step(mB, 4, 5, 16, rst, ini, int'(bajoB), int'(altoB), 40'(occB), 8'(empB), 8'(errB));
        #1;
        cmp("A", mA, estA, int'(boA), int'(aoA), aeA, afA, eidA, pA, idA, acA, erA);
        cmp("B", mB, estB, int'(boB), int'(aoB), 8'(aeB), 8'(afB), 8'(eidB), pB, idB, acB, erB);
    endtask

    initial begin
        rst = 1; ini = 0;
        bajoA = 0; altoA = 0; occA = 0; empA = 8'hFF; errA = 0;
        bajoB = 0; altoB = 0; occB = 0; empB = 4'hF;  errB = 0;
        tick(); tick();
        chk("lit.reset_estado", int'(estA), 0);
        chk("lit.reset_bajo", int'(boA), 1);
        chk("lit.reset_alto", int'(aoA), 6);
        chk("lit.reset_pausa", int'(pA), 0);

        // reset then init with 2/5 (B: 2/14)
        rst = 0; ini = 1; bajoA = 2; altoA = 5; bajoB = 2; altoB = 14;
        tick();
        chk("lit.init_estado", int'(estA), 1);
        chk("lit.init_pausa", int'(pA), 1);
        ini = 0;
        tick();
        chk("lit.idle_estado", int'(estA), 2);
        chk("lit.latched_bajo", int'(boA), 2);
        chk("lit.latched_alto", int'(aoA), 5);
        chk("lit.B_latched_alto", int'(aoB), 14);

        // invalid thresholds are ignored
        ini = 1;
        tick();
        bajoA = 5; altoA = 3;
        tick();
        altoA = 9;
        tick();
        chk("lit.inval_bajo", int'(boA), 2);
        chk("lit.inval_alto", int'(aoA), 5);
        bajoA = 2; altoA = 5; ini = 0;
        tick();

        // traffic on FIFO 3
        occA[15:12] = 4'd5; empA = 8'hF7;
        occB[19:15] = 5'd14; empB = 4'h7;
        tick();
        chk("lit.traffic_estado", int'(estA), 3);
        chk("lit.traffic_af", int'(afA), 8'h08);
        chk("lit.traffic_ae", int'(aeA), 8'hF7);
        chk("lit.traffic_pausa", int'(pA), 1);
        chk("lit.B_af_slice", int'(afB), 4'h8);
        occA[15:12] = 4'd1;
        tick();
        chk("lit.drain_ae", int'(aeA), 8'hFF);
        chk("lit.drain_pausa", int'(pA), 0);
        empA = 8'hFF; empB = 4'hF;
        tick();
        chk("lit.allempty_estado", int'(estA), 2);

        // error priority over init, sticky accumulation, absorbing
        empA = 8'hF7;
        tick();
        errA = 8'h04; ini = 1;
        tick();
        chk("lit.err_estado", int'(estA), 4);
        chk("lit.err_id", int'(eidA), 8'h04);
        chk("lit.err_pausa", int'(pA), 1);
        errA = 0; ini = 0;
        tick();
        errA = 8'h10;
        tick();
        chk("lit.err_id_acc", int'(eidA), 8'h14);
        errA = 0; ini = 1;
        tick();
        ini = 0;
        tick();
        chk("lit.err_absorb", int'(estA), 4);

        // reset during ERROR and during INIT
        rst = 1;
        tick();
        chk("lit.rst_err_estado", int'(estA), 0);
        chk("lit.rst_err_id", int'(eidA), 0);
        rst = 0; ini = 1;
        tick(); tick();
        chk("lit.reinit_bajo", int'(boA), 2);
        rst = 1;
        tick();
        chk("lit.rst_init_bajo", int'(boA), 1);
        chk("lit.rst_init_alto", int'(aoA), 6);
        rst = 0; ini = 0;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 47) == 0);
            ini   = ($urandom_range(0, 7) == 0);
            bajoA = 4'($urandom_range(0, 9));
            altoA = 4'($urandom_range(0, 10));
            bajoB = 5'($urandom_range(0, 18));
            altoB = 5'($urandom_range(0, 19));
            occA  = $urandom;
            occB  = 20'($urandom);
            empA  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            empB  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            errA  = ($urandom_range(0, 59) == 0) ? 8'($urandom) : 8'h00;
            errB  = ($urandom_range(0, 59) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
